artec_dma_task_sched: RTL



---
 rtl/artec_dma_task_sched_pkg.sv | 24 ++
 rtl/artec_dma_task_sched_if.sv | 21 ++
 rtl/artec_dma_task_sched_fb_pick.sv | 30 +++
 rtl/artec_dma_task_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/artec_dma_task_sched_pkg.sv
// Shared types and constants for the DMA task scheduler and the header stage.
package artec_dma_task_sched_pkg;

    localparam int PKG_ADDR_W = 32;

    // Byte offsets inside a frame buffer: header first, payload after it.
    localparam logic [31:0] PKG_OFFSET_HEADER = 32'h0000_0000;
    localparam logic [31:0] PKG_OFFSET_DATA   = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2
    } task_sched_state_t;

    // Task word as consumed by the header/flush stage.
    typedef struct packed {
        logic                  sync;
        logic [15:0]           data_num;
        logic [PKG_ADDR_W-1:0] address;
        logic [2:0]            fnum;
    } sched_task_t;

endpackage

// File: rtl/artec_dma_task_sched_if.sv
// Task handshake bus between the scheduler (master) and the header stage (slave).
interface artec_dma_task_sched_if #(
    parameter int ADDR_W = 32
);
    logic              task_valid_o;
    logic              task_ready_i;
    logic              task_sync_o;
    logic [15:0]       task_data_num_o;
    logic [ADDR_W-1:0] task_address_o;
    logic [2:0]        task_fnum_o;

    modport master (
        output task_valid_o, task_sync_o, task_data_num_o, task_address_o, task_fnum_o,
        input  task_ready_i
    );

    modport slave (
        input  task_valid_o, task_sync_o, task_data_num_o, task_address_o, task_fnum_o,
        output task_ready_i
    );
endinterface

// File: rtl/artec_dma_task_sched_fb_pick.sv
// Rotating first-free search over the frame buffer lock vector.
module artec_dma_task_sched_fb_pick #(
    parameter int FB_NUM = 4
) (
    input  logic [FB_NUM-1:0] lock,
    input  logic [2:0]        start_idx,
    output logic              found,
    output logic [2:0]        idx
);
    logic [7:0] lock8_s;

    assign lock8_s = 8'(lock);

    // Walk start_idx, start_idx+1, ... (mod FB_NUM) and stop at the first unlocked buffer.
    always_comb begin : search
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        cand  = 3'd0;
        for (int k = 0; k < FB_NUM; k++) begin
            cand = 3'((int'(start_idx) + k) % FB_NUM);
            if (!found && !lock8_s[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
    end
endmodule

// File: rtl/artec_dma_task_sched.sv
// Frame-level task scheduler: round-robin buffer pick, burst split, task issue.
module artec_dma_task_sched
    import artec_dma_task_sched_pkg::*;
#(
    parameter int FB_NUM     = 4,
    parameter int ADDR_W     = 32,
    parameter int BURST_MAX  = 256,
    parameter int FRAME_W    = 24,
    parameter int ADDR_SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     clear_i,
    input  logic [FRAME_W-1:0]       frame_words_i,
    input  logic [FB_NUM*ADDR_W-1:0] fb_addr_i,
    input  logic [FB_NUM-1:0]        fb_lock_i,
    artec_dma_task_sched_if.master   tsk,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic                     cfg_err_o,
    output logic [31:0]              frame_cnt_o
);
    localparam logic [FRAME_W-1:0] BURST_W   = FRAME_W'(BURST_MAX);
    localparam logic [FRAME_W-1:0] ZERO_W    = {FRAME_W{1'b0}};
    localparam logic [2:0]         LAST_FNUM = 3'(FB_NUM - 1);

    task_sched_state_t  state_r, state_n;
    logic [2:0]         cur_fnum_r, cur_fnum_n;
    logic [FRAME_W-1:0] rem_r, rem_n, offset_r, offset_n, num_s, num_n_s;
    logic [ADDR_W-1:0]  base_r, base_n, pick_base_s;
    logic               stop_pending_r, stop_pending_n;
    logic               overrun_r, overrun_n, cfg_err_r, cfg_err_n;
    logic [31:0]        frame_cnt_r, frame_cnt_n;
    sched_task_t        task_r, task_n;
    logic               valid_r, valid_n, busy_r, busy_n;
    logic               hs_s, pick_found_s;
    logic [2:0]         pick_start_s, pick_idx_s;

    function automatic logic [FRAME_W-1:0] burst_len(input logic [FRAME_W-1:0] rem);
        if (rem > BURST_W) begin
            burst_len = BURST_W;
        end else begin
            burst_len = rem;
        end
    endfunction

    assign hs_s         = valid_r & tsk.task_ready_i;
    assign num_s        = burst_len(rem_r);
    assign pick_start_s = (cur_fnum_r >= LAST_FNUM) ? 3'd0 : cur_fnum_r + 3'd1;
    assign pick_base_s  = fb_addr_i[int'(pick_idx_s)*ADDR_W +: ADDR_W];

    artec_dma_task_sched_fb_pick #(.FB_NUM(FB_NUM)) u_fb_pick (
        .lock      (fb_lock_i),
        .start_idx (pick_start_s),
        .found     (pick_found_s),
        .idx       (pick_idx_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state decision; clear overrides everything.
    always_comb begin
        state_n = state_r;
        if (clear_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_n = start_i ? ST_SELECT : ST_IDLE;
                ST_SELECT: begin
                    if (stop_pending_r || (frame_words_i == ZERO_W)) begin
                        state_n = ST_IDLE;
                    end else if (pick_found_s) begin
                        state_n = ST_ISSUE;
                    end else begin
                        state_n = ST_SELECT;
                    end
                end
                ST_ISSUE: begin
                    if (hs_s && task_r.sync) begin
                        state_n = stop_pending_r ? ST_IDLE : ST_SELECT;
                    end else begin
                        state_n = ST_ISSUE;
                    end
                end
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values; task fields are built from the post-edge rem/offset.
    always_comb begin
        cur_fnum_n     = cur_fnum_r;
        rem_n          = rem_r;
        offset_n       = offset_r;
        base_n         = base_r;
        stop_pending_n = stop_pending_r;
        overrun_n      = overrun_r;
        cfg_err_n      = cfg_err_r;
        frame_cnt_n    = frame_cnt_r;
        if (clear_i) begin
            cur_fnum_n     = LAST_FNUM;
            rem_n          = ZERO_W;
            offset_n       = ZERO_W;
            base_n         = {ADDR_W{1'b0}};
            stop_pending_n = 1'b0;
            overrun_n      = 1'b0;
            cfg_err_n      = 1'b0;
            frame_cnt_n    = 32'd0;
        end else begin
            case (state_r)
                ST_SELECT: begin
                    if (stop_pending_r) begin
                        cfg_err_n = cfg_err_r;
                    end else if (frame_words_i == ZERO_W) begin
                        cfg_err_n = 1'b1;
                    end else if (pick_found_s) begin
                        cur_fnum_n = pick_idx_s;
                        rem_n      = frame_words_i;
                        offset_n   = ZERO_W;
                        base_n     = pick_base_s + ADDR_W'(PKG_OFFSET_DATA);
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (hs_s) begin
                        rem_n    = rem_r - num_s;
                        offset_n = offset_r + num_s;
                        if (task_r.sync) begin
                            frame_cnt_n = frame_cnt_r + 32'd1;
                        end else begin
                            frame_cnt_n = frame_cnt_r;
                        end
                    end else begin
                        rem_n = rem_r;
                    end
                end
                default: rem_n = rem_r;
            endcase
            if (state_n == ST_IDLE) begin
                stop_pending_n = 1'b0;
            end else if (stop_i) begin
                stop_pending_n = 1'b1;
            end else begin
                stop_pending_n = stop_pending_r;
            end
        end
        valid_n = (state_n == ST_ISSUE);
        busy_n  = (state_n != ST_IDLE);
        num_n_s = burst_len(rem_n);
        if (valid_n) begin
            task_n.sync     = (rem_n <= BURST_W);
            task_n.data_num = 16'(num_n_s);
            task_n.address  = PKG_ADDR_W'(base_n + (ADDR_W'(offset_n) << ADDR_SHIFT));
            task_n.fnum     = cur_fnum_n;
        end else begin
            task_n = {$bits(sched_task_t){1'b0}};
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_fnum_r     <= LAST_FNUM;
            rem_r          <= ZERO_W;
            offset_r       <= ZERO_W;
            base_r         <= {ADDR_W{1'b0}};
            stop_pending_r <= 1'b0;
            overrun_r      <= 1'b0;
            cfg_err_r      <= 1'b0;
            frame_cnt_r    <= 32'd0;
            task_r         <= {$bits(sched_task_t){1'b0}};
            valid_r        <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            cur_fnum_r     <= cur_fnum_n;
            rem_r          <= rem_n;
            offset_r       <= offset_n;
            base_r         <= base_n;
            stop_pending_r <= stop_pending_n;
            overrun_r      <= overrun_n;
            cfg_err_r      <= cfg_err_n;
            frame_cnt_r    <= frame_cnt_n;
            task_r         <= task_n;
            valid_r        <= valid_n;
            busy_r         <= busy_n;
        end
    end

    assign tsk.task_valid_o    = valid_r;
    assign tsk.task_sync_o     = task_r.sync;
    assign tsk.task_data_num_o = task_r.data_num;
    assign tsk.task_address_o  = ADDR_W'(task_r.address);
    assign tsk.task_fnum_o     = task_r.fnum;
    assign busy_o              = busy_r;
    assign overrun_o           = overrun_r;
    assign cfg_err_o           = cfg_err_r;
    assign frame_cnt_o         = frame_cnt_r;
endmodule
